hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller, successor to the 2-operand/2-stage forwarding detector. It performs:
- forwarding select for NUM_SRC ID-stage operands across FWD_STAGES younger-to-older producer stages;
- load-use stall detection with a configurable earliest load-forward stage;
- multi-cycle EX-op stalling via an FSM and counter;
- redirect flushing and performance counting.

It sits beside the ID/EX pipeline registers and drives their enable and flush controls and the operand-mux selects.

Parameters:
NUM_SRC, 2, source operands checked in ID
REG_ADDR_W, 5, register address width
FWD_STAGES, 3, producer stages checked; index 0 = EX (youngest), ascending = older
LOAD_FWD_STAGE, 1, lowest stage index whose load result is forwardable; 1..FWD_STAGES-1
MC_LATENCY, 4, total EX cycles of a multi-cycle op; >=1
CNT_W, 32, perf counter width
(derived) SEL_W = $clog2(FWD_STAGES+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
src_addr  in  NUM_SRC*REG_ADDR_W  ID source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
src_valid  in  NUM_SRC  operand i actually read
stage_rd_addr  in  FWD_STAGES*REG_ADDR_W  destination address per stage
stage_regwrite  in  FWD_STAGES  stage k writes register file
stage_is_load  in  FWD_STAGES  stage k holds a load
mc_start  in  1  first EX cycle of a multi-cycle op
ex_redirect  in  1  taken branch/jump resolved in EX
fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = regfile, k+1 = forward from stage k
stall_if, stall_id, stall_ex  out  1 each  hold PC / IF-ID / ID-EX registers
flush_id, flush_ex, flush_mem  out  1 each  bubble into IF-ID / ID-EX / EX-MEM
mc_busy  out  1  registered; FSM in MC_BUSY
perf_stall_cnt  out  CNT_W  cycles with stall_if=1
perf_flush_cnt  out  CNT_W  redirect events

Behaviour:
Forwarding (combinational):
- For operand i with src_valid[i]=1 and src_addr!=0, find the lowest k with stage_regwrite[k] and stage_rd_addr[k]==src_addr; set fwd_sel = k+1.
- Younger matches mask older matches. Otherwise fwd_sel = 0.
- Load-use: the matching k is a load with k<LOAD_FWD_STAGE. Hazard asserted for that operand and its fwd_sel = 0.

FSM: states RUN, MC_BUSY; register mc_cnt.
- RUN + mc_start (not redirect):
  - stall_if/id/ex=1 and flush_mem=1 this cycle.
  - If MC_LATENCY>=3: go MC_BUSY, mc_cnt=MC_LATENCY-2.
  - If MC_LATENCY=2: stall this cycle only, stay RUN.
  - If MC_LATENCY=1: no stall.
- MC_BUSY:
  - stall_if/id/ex=1, flush_mem=1; mc_cnt decrements.
  - When mc_cnt==1, go RUN next cycle.
  - Total stall = MC_LATENCY-1 cycles including the start cycle.
  - mc_start and ex_redirect are ignored.
- Priority (high to low): rst > MC stall > ex_redirect > load-use.
  - Redirect: flush_id=flush_ex=1, no stall, load-use suppressed.
  - Load-use (RUN, no redirect, no mc_start): stall_if=stall_id=1, flush_ex=1, stall_ex=0, flush_mem=0.
  - mc_start together with ex_redirect: redirect wins, mc_start ignored.

Perf counters:
- Both are registered and wrap at 2^CNT_W.
- perf_stall_cnt +1 per cycle with stall_if=1.
- perf_flush_cnt +1 per cycle with redirect acted on.

Reset:
- Next state RUN, mc_cnt=0, mc_busy=0, counters=0.
- While rst=1: stall_* = 0, flush_id=flush_ex=1, flush_mem=0, fwd_sel=0.
- Reset mid-MC_BUSY aborts the op; RUN on the next cycle.

Test Plan:
1. src0=x5 valid; stage0 rd=5 rw=1; stage1 rd=5 rw=1 -> fwd_sel0=1. Clear stage0 rw -> 2. src0=x0 -> 0. src_valid0=0 -> 0.
2. Defaults; stage0 load rd=7; src1=x7 valid -> stall_if=stall_id=flush_ex=1, fwd_sel1=0, perf_stall_cnt+1. Next cycle load moves to stage1 -> fwd_sel1=2, no stall.
3. MC_LATENCY=4; mc_start at cycle t -> stall_if/id/ex and flush_mem=1 on t, t+1, t+2 and low on t+3; mc_busy=1 on t+1, t+2; perf_stall_cnt +3. mc_start re-asserted during MC_BUSY has no effect.
4. ex_redirect with a simultaneous load-use match -> flush_id=flush_ex=1, stall_if=0, perf_flush_cnt+1.
5. rst asserted at t+1 of a MC_LATENCY=4 op -> flush_id=flush_ex=1 while in reset. After release: RUN, mc_busy=0, counters=0, no residual stall.
6. NUM_SRC=3, FWD_STAGES=4, LOAD_FWD_STAGE=2: stage1 load rd=9 matching src2 -> stall. Same load in stage2 -> fwd_sel2=3, no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use and multi-cycle stalls,
// redirect flushes and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned FWD_STAGES     = 3,
    parameter int unsigned LOAD_FWD_STAGE = 1,
    parameter int unsigned MC_LATENCY     = 4,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned SEL_W         = $clog2(FWD_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd_addr,
    input  logic [FWD_STAGES-1:0]            stage_regwrite,
    input  logic [FWD_STAGES-1:0]            stage_is_load,
    input  logic                             mc_start,
    input  logic                             ex_redirect,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
    output logic                             stall_if,
    output logic                             stall_id,
    output logic                             stall_ex,
    output logic                             flush_id,
    output logic                             flush_ex,
    output logic                             flush_mem,
    output logic                             mc_busy,
    output logic [CNT_W-1:0]                 perf_stall_cnt,
    output logic [CNT_W-1:0]                 perf_flush_cnt
);

    localparam int unsigned MC_W    = (MC_LATENCY >= 2) ? $clog2(MC_LATENCY) : 1;
    localparam int unsigned MC_INIT = (MC_LATENCY >= 3) ? MC_LATENCY - 2 : 0;

    typedef enum logic {StRun, StMcBusy} state_e;

    state_e                   state_q, state_d;
    logic [MC_W-1:0]          mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]         stall_cnt_q, flush_cnt_q;
    logic [NUM_SRC*SEL_W-1:0] sel_raw;
    logic [NUM_SRC-1:0]       load_hit;
    logic                     load_use;
    logic                     redirect_act;

    // Scan oldest to youngest so the youngest matching producer is written last and wins.
    always_comb begin
        sel_raw  = '0;
        load_hit = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
                if (src_valid[i] && (src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                    stage_regwrite[k] &&
                    (stage_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] ==
                     src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    sel_raw[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    load_hit[i] = stage_is_load[k] && (k < int'(LOAD_FWD_STAGE));
                end
            end
            if (load_hit[i]) begin
                sel_raw[i*SEL_W +: SEL_W] = '0;
            end
        end
    end

    assign load_use = |load_hit;

    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        fwd_sel      = sel_raw;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        flush_mem    = 1'b0;
        redirect_act = 1'b0;
        if (rst) begin
            state_d  = StRun;
            mc_cnt_d = '0;
            fwd_sel  = '0;
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (state_q == StMcBusy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
            mc_cnt_d  = mc_cnt_q - MC_W'(1);
            if (mc_cnt_q == MC_W'(1)) begin
                state_d = StRun;
            end
        end else if (ex_redirect) begin
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            redirect_act = 1'b1;
        end else if (mc_start && (MC_LATENCY >= 2)) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
            if (MC_LATENCY >= 3) begin
                state_d  = StMcBusy;
                mc_cnt_d = MC_W'(MC_INIT);
            end
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            if (stall_if) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_act) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mc_busy        = (state_q == StMcBusy);
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: default configuration plus a 3-operand/4-stage instance.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Default instance: NUM_SRC=2, FWD_STAGES=3, LOAD_FWD_STAGE=1, MC_LATENCY=4
    logic [9:0]  src_addr;
    logic [1:0]  src_valid;
    logic [14:0] stage_rd_addr;
    logic [2:0]  stage_regwrite, stage_is_load;
    logic        mc_start, ex_redirect;
    logic [3:0]  fwd_sel;
    logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mc_busy;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    hazard_ctrl #(
        .NUM_SRC(2), .REG_ADDR_W(5), .FWD_STAGES(3), .LOAD_FWD_STAGE(1),
        .MC_LATENCY(4), .CNT_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .src_addr(src_addr), .src_valid(src_valid),
        .stage_rd_addr(stage_rd_addr), .stage_regwrite(stage_regwrite),
        .stage_is_load(stage_is_load), .mc_start(mc_start), .ex_redirect(ex_redirect),
        .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .mc_busy(mc_busy),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    // Wide instance: NUM_SRC=3, FWD_STAGES=4, LOAD_FWD_STAGE=2
    logic [14:0] src_addr_b;
    logic [2:0]  src_valid_b;
    logic [19:0] stage_rd_addr_b;
    logic [3:0]  stage_regwrite_b, stage_is_load_b;
    logic [8:0]  fwd_sel_b;
    logic        stall_if_b, stall_id_b, stall_ex_b, flush_id_b, flush_ex_b, flush_mem_b;
    logic        mc_busy_b;
    logic [31:0] perf_stall_cnt_b, perf_flush_cnt_b;

    hazard_ctrl #(
        .NUM_SRC(3), .REG_ADDR_W(5), .FWD_STAGES(4), .LOAD_FWD_STAGE(2),
        .MC_LATENCY(4), .CNT_W(32)
    ) u_dut_b (
        .clk(clk), .rst(rst), .src_addr(src_addr_b), .src_valid(src_valid_b),
        .stage_rd_addr(stage_rd_addr_b), .stage_regwrite(stage_regwrite_b),
        .stage_is_load(stage_is_load_b), .mc_start(1'b0), .ex_redirect(1'b0),
        .fwd_sel(fwd_sel_b), .stall_if(stall_if_b), .stall_id(stall_id_b),
        .stall_ex(stall_ex_b), .flush_id(flush_id_b), .flush_ex(flush_ex_b),
        .flush_mem(flush_mem_b), .mc_busy(mc_busy_b),
        .perf_stall_cnt(perf_stall_cnt_b), .perf_flush_cnt(perf_flush_cnt_b)
    );

    typedef struct packed {
        logic [3:0]  fsel;
        logic        sif, sid, sex, fid, fex, fmem, busy;
        logic [31:0] scnt, fcnt;
    } exp_a_t;

    typedef struct packed {
        logic [8:0] fsel;
        logic       sif, sex, fex;
    } exp_b_t;

    exp_a_t      q_a[$];
    exp_b_t      q_b[$];
    logic [31:0] model_scnt = 0;
    logic [31:0] model_fcnt = 0;

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            exp_a_t e;
            e = q_a.pop_front();
            check_eq("fwd_sel",        32'(fwd_sel),   32'(e.fsel));
            check_eq("stall_if",       32'(stall_if),  32'(e.sif));
            check_eq("stall_id",       32'(stall_id),  32'(e.sid));
            check_eq("stall_ex",       32'(stall_ex),  32'(e.sex));
            check_eq("flush_id",       32'(flush_id),  32'(e.fid));
            check_eq("flush_ex",       32'(flush_ex),  32'(e.fex));
            check_eq("flush_mem",      32'(flush_mem), 32'(e.fmem));
            check_eq("mc_busy",        32'(mc_busy),   32'(e.busy));
            check_eq("perf_stall_cnt", perf_stall_cnt, e.scnt);
            check_eq("perf_flush_cnt", perf_flush_cnt, e.fcnt);
        end
        if (q_b.size() > 0) begin
            exp_b_t e;
            e = q_b.pop_front();
            check_eq("b_fwd_sel",  32'(fwd_sel_b),  32'(e.fsel));
            check_eq("b_stall_if", 32'(stall_if_b), 32'(e.sif));
            check_eq("b_stall_ex", 32'(stall_ex_b), 32'(e.sex));
            check_eq("b_flush_ex", 32'(flush_ex_b), 32'(e.fex));
        end
    end

    // Push this cycle's expectation, then advance one clock.
    task automatic step(input logic [3:0] fsel, input logic sif, input logic sid,
                        input logic sex, input logic fid, input logic fex, input logic fmem,
                        input logic busy, input logic redir);
        exp_a_t e;
        e = '{fsel: fsel, sif: sif, sid: sid, sex: sex, fid: fid, fex: fex, fmem: fmem,
              busy: busy, scnt: model_scnt, fcnt: model_fcnt};
        q_a.push_back(e);
        if (sif)   model_scnt = model_scnt + 1;
        if (redir) model_fcnt = model_fcnt + 1;
        if (rst) begin
            model_scnt = 0;
            model_fcnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [8:0] fsel, input logic sif, input logic sex,
                          input logic fex);
        q_b.push_back('{fsel: fsel, sif: sif, sex: sex, fex: fex});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_addr = '0; src_valid = '0; stage_rd_addr = '0;
        stage_regwrite = '0; stage_is_load = '0; mc_start = 1'b0; ex_redirect = 1'b0;
        src_addr_b = '0; src_valid_b = '0; stage_rd_addr_b = '0;
        stage_regwrite_b = '0; stage_is_load_b = '0;
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input logic v);
        src_addr[i*5 +: 5] = a;
        src_valid[i]       = v;
    endtask

    task automatic set_stage(input int k, input logic [4:0] rd, input logic rw, input logic ld);
        stage_rd_addr[k*5 +: 5] = rd;
        stage_regwrite[k]       = rw;
        stage_is_load[k]        = ld;
    endtask

    task automatic set_src_b(input int i, input logic [4:0] a, input logic v);
        src_addr_b[i*5 +: 5] = a;
        src_valid_b[i]       = v;
    endtask

    task automatic set_stage_b(input int k, input logic [4:0] rd, input logic rw,
                               input logic ld);
        stage_rd_addr_b[k*5 +: 5] = rd;
        stage_regwrite_b[k]       = rw;
        stage_is_load_b[k]        = ld;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset overrides a live forward match and a multi-cycle start
        set_src(0, 5'd5, 1'b1);
        set_stage(0, 5'd5, 1'b1, 1'b0);
        mc_start = 1'b1;
        step(4'h0, 0, 0, 0, 1, 1, 0, 0, 0);
        rst = 1'b0;

        // Forwarding priority and masking
        clear_inputs();
        set_src(0, 5'd5, 1'b1);
        set_stage(0, 5'd5, 1'b1, 1'b0);
        set_stage(1, 5'd5, 1'b1, 1'b0);
        step(4'h1, 0, 0, 0, 0, 0, 0, 0, 0);
        set_stage(0, 5'd5, 1'b0, 1'b0);
        step(4'h2, 0, 0, 0, 0, 0, 0, 0, 0);
        set_src(1, 5'd3, 1'b1);
        set_stage(2, 5'd3, 1'b1, 1'b0);
        step(4'hE, 0, 0, 0, 0, 0, 0, 0, 0);
        set_src(0, 5'd0, 1'b1);
        set_stage(0, 5'd0, 1'b1, 1'b0);
        step(4'hC, 0, 0, 0, 0, 0, 0, 0, 0);
        set_src(0, 5'd5, 1'b0);
        step(4'hC, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use
        clear_inputs();
        set_stage(0, 5'd7, 1'b1, 1'b1);
        set_src(1, 5'd7, 1'b1);
        step(4'h0, 1, 1, 0, 0, 1, 0, 0, 0);
        set_stage(0, 5'd0, 1'b0, 1'b0);
        set_stage(1, 5'd7, 1'b1, 1'b1);
        step(4'h8, 0, 0, 0, 0, 0, 0, 0, 0);
        set_stage(0, 5'd7, 1'b1, 1'b1);
        set_stage(1, 5'd7, 1'b1, 1'b0);
        step(4'h0, 1, 1, 0, 0, 1, 0, 0, 0);
        set_stage(0, 5'd7, 1'b0, 1'b1);
        step(4'h8, 0, 0, 0, 0, 0, 0, 0, 0);

        // Multi-cycle op, MC_LATENCY=4
        clear_inputs();
        mc_start = 1'b1;
        step(4'h0, 1, 1, 1, 0, 0, 1, 0, 0);
        ex_redirect = 1'b1;
        step(4'h0, 1, 1, 1, 0, 0, 1, 1, 0);
        mc_start = 1'b0;
        ex_redirect = 1'b0;
        set_stage(0, 5'd7, 1'b1, 1'b1);
        set_src(1, 5'd7, 1'b1);
        step(4'h0, 1, 1, 1, 0, 0, 1, 1, 0);
        clear_inputs();
        step(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Redirect beats load-use and mc_start
        set_stage(0, 5'd7, 1'b1, 1'b1);
        set_src(1, 5'd7, 1'b1);
        ex_redirect = 1'b1;
        step(4'h0, 0, 0, 0, 1, 1, 0, 0, 1);
        clear_inputs();
        mc_start = 1'b1;
        ex_redirect = 1'b1;
        step(4'h0, 0, 0, 0, 1, 1, 0, 0, 1);
        clear_inputs();
        step(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset aborts an op in flight and clears counters
        mc_start = 1'b1;
        step(4'h0, 1, 1, 1, 0, 0, 1, 0, 0);
        mc_start = 1'b0;
        rst = 1'b1;
        step(4'h0, 0, 0, 0, 1, 1, 0, 1, 0);
        rst = 1'b0;
        step(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Wide instance, LOAD_FWD_STAGE=2
        clear_inputs();
        set_stage_b(1, 5'd9, 1'b1, 1'b1);
        set_src_b(2, 5'd9, 1'b1);
        step_b(9'h000, 1, 0, 1);
        set_stage_b(1, 5'd0, 1'b0, 1'b0);
        set_stage_b(2, 5'd9, 1'b1, 1'b1);
        step_b(9'h0C0, 0, 0, 0);
        set_stage_b(2, 5'd0, 1'b0, 1'b0);
        set_stage_b(3, 5'd9, 1'b1, 1'b0);
        set_src_b(0, 5'd9, 1'b1);
        step_b(9'h104, 0, 0, 0);
        set_stage_b(0, 5'd9, 1'b1, 1'b1);
        step_b(9'h000, 1, 0, 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
